write_buffer: RTL

Posted-write FIFO between the data cache and the RAM port. Write-through stores from the cache are queued and return immediately; queued stores drain to RAM whenever the cache is not reading. Reads bypass the queue unless they hit a pending store, in which case the queue drains first. Keeps store latency off the MEM stage while preserving program-order memory semantics.

---
 rtl/write_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/write_buffer.sv
// ---------------------------------------------------------------------------
// write_buffer
//
// Posted-write FIFO sitting between the data cache and the RAM port.
// Write-through stores are queued and acknowledged immediately. Queued stores
// drain to RAM in enqueue order on every cycle the cache is not reading. A read
// that hits a pending store (same word address) stalls until every matching
// store has drained, so memory is always seen in program order.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cache_ce_i        request valid from the cache
//   cache_we_i        1 = store (enqueue), 0 = load
//   cache_addr_i      byte address (bits [1:0] ignored for matching)
//   cache_sel_i       byte enables
//   cache_data_i      store data
//   cache_data_o      load data returned to the cache
//   stallreq          request not completed this cycle, hold inputs
//   ram_ce_o/we_o     RAM chip enable / write enable
//   ram_addr_o        RAM address
//   ram_sel_o         RAM byte enables
//   ram_data_o        RAM write data
//   ram_data_i        RAM read data (combinational during a read)
//   buf_empty_o       queue holds no pending stores
// ---------------------------------------------------------------------------
module write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_ce_i,
    input  logic        cache_we_i,
    input  logic [31:0] cache_addr_i,
    input  logic [3:0]  cache_sel_i,
    input  logic [31:0] cache_data_i,
    output logic [31:0] cache_data_o,
    output logic        stallreq,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        buf_empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Entry storage; contents are only meaningful while count-bounded.
    logic [31:0] addr_mem [DEPTH];
    logic [3:0]  sel_mem  [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic             is_read;
    logic             is_write;
    logic [DEPTH-1:0] hit;
    logic             match;
    logic             read_free;
    logic             deq;
    logic             enq;

    assign is_read  = cache_ce_i & ~cache_we_i;
    assign is_write = cache_ce_i & cache_we_i;

    // An entry is live when its distance from head (mod DEPTH) is below count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [AW-1:0] offset;
            assign offset  = IDX - head_q;
            assign hit[gi] = ({1'b0, offset} < count_q)
                           && (addr_mem[gi][31:2] == cache_addr_i[31:2]);
        end
    endgenerate

    assign match     = |hit;
    // An unmatched read owns the RAM port this cycle; otherwise the queue drains.
    assign read_free = is_read & ~match;
    assign deq       = ~read_free & (count_q != '0);
    // A full queue still accepts a store when its head leaves in the same cycle.
    assign enq       = is_write & ((count_q < FULL_COUNT) | deq);

    assign stallreq     = (is_read & match) | (is_write & ~enq);
    assign cache_data_o = read_free ? ram_data_i : 32'h0;
    assign buf_empty_o  = (count_q == '0);

    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'h0;
        ram_sel_o  = 4'h0;
        ram_data_o = 32'h0;
        if (read_free) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = cache_addr_i;
            ram_sel_o  = cache_sel_i;
        end else if (deq) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = addr_mem[head_q];
            ram_sel_o  = sel_mem[head_q];
            ram_data_o = data_mem[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            head_d = head_q + AW'(1);
        end
        if (enq) begin
            tail_d = tail_q + AW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: a cleared count makes every entry dead.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_q] <= cache_addr_i;
            sel_mem[tail_q]  <= cache_sel_i;
            data_mem[tail_q] <= cache_data_i;
        end
    end

endmodule
